// File: rtl/rsa_modexp_ctrl_pkg.sv
// Shared types and constants for the RSA modular-exponentiation sequencer.
`timescale 1ns/1ps
package rsa_modexp_ctrl_pkg;

   localparam int unsigned DATA_W        = 16;
   localparam int unsigned MODMUL_CYCLES = 64;

   // Top-level sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SQR,
      MUL,
      FIN,
      ERR
   } state_t;

   // Four adder cycles per multiplier bit inside one modular multiply.
   typedef enum logic [1:0] {
      DBL,
      RED1,
      ADD,
      RED2
   } step_t;

endpackage

// File: rtl/rsa_modexp_ctrl_my16bitadder.sv
// 16-bit ripple-carry adder with optional B inversion (A + B + Cin or A + ~B + Cin).
`timescale 1ns/1ps
module my16bitadder (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        InvB,
   input  logic        Cin,
   output logic [15:0] Sum,
   output logic        Cout
);

   // Bit-serial carry chain, LSB first.
   always_comb begin : rca
      logic        carry;
      logic [15:0] b_eff;
      Sum   = '0;
      b_eff = InvB ? ~B : B;
      carry = Cin;
      for (int unsigned i = 0; i < 16; i++) begin
         Sum[i] = A[i] ^ b_eff[i] ^ carry;
         carry  = (A[i] & b_eff[i]) | (carry & (A[i] ^ b_eff[i]));
      end
      Cout = carry;
   end

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Square-and-multiply M^E mod N sequencer time-sharing one 16-bit adder.
`timescale 1ns/1ps
module rsa_modexp_ctrl
   import rsa_modexp_ctrl_pkg::*;
#(
   parameter int unsigned EXP_BITS = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [DATA_W-1:0] M,
   input  logic [DATA_W-1:0] E,
   input  logic [DATA_W-1:0] N,
   output logic              Busy,
   output logic              Done,
   output logic              Error,
   output logic [DATA_W-1:0] Result
);

   localparam logic [3:0] EXP_TOP = 4'(EXP_BITS - 1);
   localparam logic [3:0] BIT_TOP = 4'(MODMUL_CYCLES / 4 - 1);

   state_t            state_q;
   step_t             step_q;
   logic [3:0]        bit_q;
   logic [3:0]        exp_q;
   logic [DATA_W-1:0] M_q, E_q, N_q, R_q, P_q, T_q;
   logic              Busy_q, Done_q, Error_q;
   logic [DATA_W-1:0] Result_q;

   logic [DATA_W-1:0] add_a, add_b, add_sum, red_d, opa_d;
   logic              add_inv, add_cin, add_cout;

   my16bitadder u_adder (
      .A    (add_a),
      .B    (add_b),
      .InvB (add_inv),
      .Cin  (add_cin),
      .Sum  (add_sum),
      .Cout (add_cout)
   );

   // Adder operand selection: one operation per cycle, idle outside the compute states.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_inv = 1'b0;
      add_cin = 1'b0;
      opa_d   = (state_q == MUL) ? M_q : R_q;
      case (state_q)
         CHECK: begin
            add_a   = M_q;
            add_b   = N_q;
            add_inv = 1'b1;
            add_cin = 1'b1;
         end
         SQR, MUL: begin
            case (step_q)
               DBL: begin
                  add_a = P_q;
                  add_b = P_q;
               end
               ADD: begin
                  add_a = P_q;
                  add_b = R_q[bit_q] ? opa_d : '0;
               end
               default: begin
                  add_a   = T_q;
                  add_b   = N_q;
                  add_inv = 1'b1;
                  add_cin = 1'b1;
               end
            endcase
         end
         default: ;
      endcase
      // Carry out of T - N means T >= N, so keep the difference.
      red_d = add_cout ? add_sum : T_q;
   end

   // Sequencer FSM with registered handshake outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         step_q   <= DBL;
         bit_q    <= '0;
         exp_q    <= '0;
         M_q      <= '0;
         E_q      <= '0;
         N_q      <= '0;
         R_q      <= '0;
         P_q      <= '0;
         T_q      <= '0;
         Busy_q   <= 1'b0;
         Done_q   <= 1'b0;
         Error_q  <= 1'b0;
         Result_q <= '0;
      end else begin
         Done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Start) begin
                  M_q     <= M;
                  E_q     <= E;
                  N_q     <= N;
                  R_q     <= 16'd1;
                  P_q     <= '0;
                  Error_q <= 1'b0;
                  Busy_q  <= 1'b1;
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               if ((N_q < 16'd2) || N_q[15] || add_cout) begin
                  state_q <= ERR;
               end else begin
                  step_q  <= DBL;
                  bit_q   <= BIT_TOP;
                  exp_q   <= EXP_TOP;
                  P_q     <= '0;
                  state_q <= SQR;
               end
            end
            SQR, MUL: begin
               case (step_q)
                  DBL: begin
                     T_q    <= add_sum;
                     step_q <= RED1;
                  end
                  RED1: begin
                     P_q    <= red_d;
                     step_q <= ADD;
                  end
                  ADD: begin
                     T_q    <= add_sum;
                     step_q <= RED2;
                  end
                  default: begin
                     step_q <= DBL;
                     bit_q  <= bit_q - 4'd1;
                     if (bit_q == '0) begin
                        // Last reduction of the multiply: result goes straight to R; P restarts at 0.
                        P_q <= '0;
                        if (state_q == SQR) begin
                           R_q     <= red_d;
                           state_q <= MUL;
                        end else begin
                           if (E_q[exp_q]) R_q <= red_d;
                           if (exp_q == '0) begin
                              state_q <= FIN;
                           end else begin
                              exp_q   <= exp_q - 4'd1;
                              state_q <= SQR;
                           end
                        end
                     end else begin
                        P_q <= red_d;
                     end
                  end
               endcase
            end
            FIN: begin
               Result_q <= R_q;
               Done_q   <= 1'b1;
               Busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            ERR: begin
               Result_q <= '0;
               Error_q  <= 1'b1;
               Done_q   <= 1'b1;
               Busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Busy   = Busy_q;
   assign Done   = Done_q;
   assign Error  = Error_q;
   assign Result = Result_q;

endmodule

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
Sequencer that computes Result = M^E mod N for the RSA encryption path using square-and-multiply. Each modular multiplication is interleaved shift-add with reduction after every step. All arithmetic (add, double, subtract-N, compare) is time-shared on one 16-bit ripple-carry adder instance. The block owns that adder, schedules one operation per cycle and presents a Start/Busy/Done handshake to the key-handling logic above it.

Parameters:
EXP_BITS, 16, exponent bits processed MSB-first starting at bit EXP_BITS-1; legal range 1..16. Higher bits of E are ignored.

Ports:
Clk  input  1  clock
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only while Busy=0
M  input  16  message/base; latched on Start accept
E  input  16  exponent; latched on Start accept
N  input  16  modulus; latched on Start accept
Busy  output  1  high from the cycle after accept until the Done cycle (exclusive)
Done  output  1  one-cycle pulse; Result/Error valid in that cycle and held afterwards
Error  output  1  operand check failed (valid with Done)
Result  output  16  M^E mod N

Behaviour:
- Reset (Clk edge with Reset=1): FSM to IDLE; Busy=0, Done=0, Error=0, Result=0. Reset overrides any operation in progress; partial results are discarded.
- FSM states: IDLE -> CHECK -> (ERR | SQR) ; SQR -> MUL -> (SQR | FIN) ; ERR/FIN -> IDLE.
- Start accept: Start=1 in IDLE at edge t0 latches M, E, N and sets R=1. Start while Busy=1 is ignored. Input changes after accept are ignored.
- CHECK (1 cycle): sets Error if N<2, N[15]=1, or M>=N. The M>=N test uses the adder as M + ~N + 1; carry=1 means M>=N.
- Error path: Done=1 and Error=1 visible after edge t0+2; Result=0.
- Modular multiply P=A*B mod N, fixed 64 cycles; B is scanned bits 15..0. Per bit, 4 adder cycles:
  - (a) T = P+P.
  - (b) D = T + ~N + 1; P = carry ? D : T.
  - (c) T = P + (B[j] ? A : 0).
  - (d) Same as (b).
  - Invariant P<N holds, and 2P < 2^16 because N < 2^15, so no overflow.
- SQR: R = R*R mod N.
- MUL: P = M*R mod N is always computed (constant time). R is updated only if E[i]=1.
- Exponent loop: i runs from EXP_BITS-1 down to 0 with one SQR plus one MUL per bit.
- Normal latency: Done=1, Error=0, Result valid after edge t0 + 2 + 128*EXP_BITS. That is 2050 cycles at the default.
- E=0 (within EXP_BITS) gives Result=1.
- Done cycle: FSM is already in IDLE with Busy=0. A Start in the same cycle is accepted. Result and Error hold until the next accept, where Error clears. Result holds until the next Done.
- Adder usage: exactly one operation per cycle while Busy. The adder carry-in and B-input inversion are driven by the FSM; the adder is idle (inputs 0) in IDLE.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, CHECK, SQR, MUL, FIN, ERR);
  - the micro-step encoding (DBL, RED1, ADD, RED2);
  - constants DATA_W=16 and MODMUL_CYCLES=64.
- One sub-module: the team's existing 16-bit ripple-carry adder (my16bitadder), instantiated once; no other instances.
- The modular-multiply micro-sequencer stays inline (bit counter plus 2-bit step counter).

Test Plan:
- M=9, E=3, N=1000 -> Done after 2050 cycles, Result=729, Error=0; Busy high for exactly the cycles before Done.
- Toy RSA: M=65, E=17, N=3233 -> Result=2790. Then M=2790, E=2753, N=3233 -> Result=65. Back-to-back Start asserted in the Done cycle is accepted.
- M=4, E=13, N=497 -> 445. With EXP_BITS=4, M=4, E=13, N=497 -> 445 after 514 cycles. M=5, E=0, N=7 -> 1.
- Error cases each give Done after 2 cycles, Error=1, Result=0: M=50/N=50; N=1; N=32768. A subsequent valid Start clears Error.
- Reset asserted mid-operation (cycle 700): next edge Busy=0, Done=0, Result=0, no spurious Done. A new Start (9,3,1000) then completes correctly.
- Start pulsed at cycles 10 and 500 during an operation, with M/E/N changed: ignored, and the first operation's Result is unaffected.
